// File: rtl/nes_tetris_spi_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and engine state encoding
// for the SoC SPI FIFO master.
package nes_tetris_spi_pkg;
  localparam logic [2:0] A_RXDATA   = 3'd0;
  localparam logic [2:0] A_TXDATA   = 3'd1;
  localparam logic [2:0] A_STATUS   = 3'd2;
  localparam logic [2:0] A_CONTROL  = 3'd3;
  localparam logic [2:0] A_DIVIDER  = 3'd4;
  localparam logic [2:0] A_SLAVESEL = 3'd5;

  localparam int ST_TXE  = 0;
  localparam int ST_TXF  = 1;
  localparam int ST_RXNE = 2;
  localparam int ST_RXF  = 3;
  localparam int ST_TOE  = 4;
  localparam int ST_ROE  = 5;
  localparam int ST_BUSY = 6;

  localparam int CT_CPOL = 0;
  localparam int CT_CPHA = 1;
  localparam int CT_LSB  = 2;
  localparam int CT_SSO  = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LEAD, S_SHIFT, S_TRAIL
  } eng_state_e;
endpackage

// File: rtl/nes_tetris_spi_sync_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO only lands when a pop
// happens in the same cycle.
module nes_tetris_spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/nes_tetris_soc_spi_fifo_master.sv
// SPI master: CPU register bank, TX/RX FIFOs and a word-serialising engine
// with per-word latched mode, bursting while TX data is available.
module nes_tetris_soc_spi_fifo_master
  import nes_tetris_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_SLAVES = 1,
  parameter int DIV_RESET  = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_select,
  input  logic [2:0]            mem_addr,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [15:0]           data_from_cpu,
  output logic [15:0]           data_to_cpu,
  output logic                  irq,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] SS_n
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic rd_q, wr_q, rd, wr;
  logic [7:0] ctrl_q, div_q;
  logic [NUM_SLAVES-1:0] ssel_q;
  logic toe_q, roe_q, irq_q;
  logic [15:0] data_q, rdata;
  logic [DW-1:0] last_rx_q;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [DW-1:0] tx_rdata, rx_rdata;
  logic [CW-1:0] rx_count, tx_cnt_unused;
  logic unused_sig;

  eng_state_e state_q;
  logic [7:0] cnt_q, div_l;
  logic [5:0] edge_q, k;
  logic [DW-1:0] shreg_q, rxsh_q, sh_nxt, rx_nxt;
  logic cpha_l, lsb_l, mosi_q, sclk_q, hp_end, smp, adv;
  logic [NUM_SLAVES-1:0] ss_q;

  assign rd = spi_select & ~read_n & ~rd_q;
  assign wr = spi_select & ~write_n & ~wr_q;
  assign tx_push = wr && (mem_addr == A_TXDATA);
  assign rx_pop  = rd && (mem_addr == A_RXDATA) && !rx_empty;
  assign tx_pop  = (state_q == S_LOAD);
  assign hp_end  = (cnt_q == div_l);
  assign rx_push = (state_q == S_TRAIL) && hp_end;
  assign unused_sig = ^{data_from_cpu, tx_cnt_unused};

  nes_tetris_spi_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .rst_n(reset_n), .push_i(tx_push), .wdata_i(data_from_cpu[DW-1:0]),
    .pop_i(tx_pop), .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty),
    .count_o(tx_cnt_unused));

  nes_tetris_spi_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .rst_n(reset_n), .push_i(rx_push), .wdata_i(rxsh_q),
    .pop_i(rx_pop), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty),
    .count_o(rx_count));

  always_comb begin
    rdata = '0;
    case (mem_addr)
      A_RXDATA:   rdata[DW-1:0] = rx_empty ? last_rx_q : rx_rdata;
      A_STATUS: begin
        rdata[ST_TXE]  = tx_empty;
        rdata[ST_TXF]  = tx_full;
        rdata[ST_RXNE] = ~rx_empty;
        rdata[ST_RXF]  = rx_full;
        rdata[ST_TOE]  = toe_q;
        rdata[ST_ROE]  = roe_q;
        rdata[ST_BUSY] = (state_q != S_IDLE);
        rdata[15:8]    = 8'(rx_count);
      end
      A_CONTROL:  rdata[7:0] = ctrl_q;
      A_DIVIDER:  rdata[7:0] = div_q;
      A_SLAVESEL: rdata[NUM_SLAVES-1:0] = ssel_q;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= 1'b0; wr_q <= 1'b0;
      ctrl_q <= '0; div_q <= 8'(DIV_RESET); ssel_q <= NUM_SLAVES'(1);
      toe_q <= 1'b0; roe_q <= 1'b0; irq_q <= 1'b0;
      data_q <= '0; last_rx_q <= '0;
    end else begin
      rd_q <= spi_select & ~read_n;
      wr_q <= spi_select & ~write_n;
      if (rd) data_q <= rdata;
      if (rx_pop) last_rx_q <= rx_rdata;
      if (wr) begin
        case (mem_addr)
          A_CONTROL:  ctrl_q <= data_from_cpu[7:0];
          A_DIVIDER:  div_q  <= data_from_cpu[7:0];
          A_SLAVESEL: ssel_q <= data_from_cpu[NUM_SLAVES-1:0];
          default: ;
        endcase
      end
      // clear-on-write loses to a same-cycle overflow so no event is missed
      if (wr && mem_addr == A_STATUS) begin
        toe_q <= 1'b0;
        roe_q <= 1'b0;
      end
      if (tx_push && tx_full && !tx_pop) toe_q <= 1'b1;
      if (rx_push && rx_full && !rx_pop) roe_q <= 1'b1;
      irq_q <= |({roe_q, toe_q, ~rx_empty, tx_empty} & ctrl_q[7:4]);
    end
  end

  // k is the 1-based index of the SCLK edge ending this half-period
  assign k      = edge_q + 6'd1;
  assign smp    = (k[0] != cpha_l);
  assign adv    = (k >= 6'd2) && (k[0] == cpha_l);
  assign sh_nxt = lsb_l ? (shreg_q >> 1) : (shreg_q << 1);
  assign rx_nxt = lsb_l ? {MISO, rxsh_q[DW-1:1]} : {rxsh_q[DW-2:0], MISO};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE; cnt_q <= '0; edge_q <= '0;
      shreg_q <= '0; rxsh_q <= '0; mosi_q <= 1'b0; sclk_q <= 1'b0; ss_q <= '1;
      cpha_l <= 1'b0; lsb_l <= 1'b0; div_l <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sclk_q <= ctrl_q[CT_CPOL];
          ss_q   <= ctrl_q[CT_SSO] ? ~ssel_q : '1;
          if (!tx_empty) state_q <= S_LOAD;
        end
        S_LOAD: begin
          cpha_l  <= ctrl_q[CT_CPHA];
          lsb_l   <= ctrl_q[CT_LSB];
          div_l   <= div_q;
          shreg_q <= tx_rdata;
          mosi_q  <= ctrl_q[CT_LSB] ? tx_rdata[0] : tx_rdata[DW-1];
          ss_q    <= ~ssel_q;
          sclk_q  <= ctrl_q[CT_CPOL];
          cnt_q   <= '0;
          state_q <= S_LEAD;
        end
        S_LEAD: begin
          if (hp_end) begin
            cnt_q <= '0; edge_q <= '0; state_q <= S_SHIFT;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_SHIFT: begin
          if (hp_end) begin
            cnt_q  <= '0;
            edge_q <= k;
            sclk_q <= ~sclk_q;
            if (smp) rxsh_q <= rx_nxt;
            if (adv) begin
              shreg_q <= sh_nxt;
              mosi_q  <= lsb_l ? sh_nxt[0] : sh_nxt[DW-1];
            end
            if (k == 6'(2*DW)) state_q <= S_TRAIL;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_TRAIL: begin
          if (hp_end) begin
            cnt_q   <= '0;
            state_q <= tx_empty ? S_IDLE : S_LOAD;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_to_cpu = data_q;
  assign irq         = irq_q;
  assign MOSI        = mosi_q;
  assign SCLK        = sclk_q;
  assign SS_n        = ss_q;
endmodule
